ecc_scrub_ctrl: RTL and testbench



---
 rtl/ecc_pkg.sv | 23 ++
 rtl/ecc_scrub_ctrl_if.sv | 23 ++
 rtl/ecc_decoder.sv | 25 ++
 rtl/ecc_encoder.sv | 10 +
 rtl/ecc_scrub_ctrl.sv | 134 +++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 262 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared Hsiao (72,64) SEC-DED constants and scrub FSM state type
// Contents: DATA_W/ECC_W/WORD_W widths, scrub_state_t, HSIAO_ROWS parity-check row masks.
package ecc_pkg;
    localparam int DATA_W = 64;
    localparam int ECC_W = 8;
    localparam int WORD_W = DATA_W + ECC_W;
    typedef enum logic [2:0] {IDLE, WAIT_INT, RD_REQ, RD_WAIT, CHECK, WB_REQ, ADVANCE} scrub_state_t;
    typedef logic [ECC_W-1:0][DATA_W-1:0] hsiao_rows_t;
    // Data columns are every weight-3 code followed by the lowest weight-5 codes, so each
    // column has odd weight and is distinct; check bits use the identity columns.
    function automatic hsiao_rows_t hsiao_rows();
        hsiao_rows_t m = '0;
        int n = 0;
        for (int w = 3; w <= 5; w += 2)
            for (int v = 0; v < 256; v++)
                if ($countones(8'(v)) == w && n < DATA_W) begin
                    for (int r = 0; r < ECC_W; r++) m[r][n] = v[r];
                    n++;
                end
        return m;
    endfunction
    localparam hsiao_rows_t HSIAO_ROWS = hsiao_rows();
endpackage

// File: rtl/ecc_scrub_ctrl_if.sv
// ecc_scrub_ctrl_if: scrubber memory request/response bus
// master (scrubber): drives mem_req_valid/we/addr/wdata, samples mem_req_ready and mem_rsp_valid/rdata.
// slave (memory): the mirror image.
interface ecc_scrub_ctrl_if import ecc_pkg::*; #(
    parameter int ADDR_WIDTH = 16,
    parameter int WORD_WIDTH = WORD_W
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_we;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [WORD_WIDTH-1:0] mem_req_wdata;
    logic                  mem_rsp_valid;
    logic [WORD_WIDTH-1:0] mem_rsp_rdata;
    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/ecc_decoder.sv
// ecc_decoder: Hsiao (72,64) SEC-DED checker and corrector
// Ports: data_in/ecc_in (stored word in), data_out (corrected data), err_sbe, err_dbe.
module ecc_decoder import ecc_pkg::*; (
    input  logic [DATA_W-1:0] data_in,
    input  logic [ECC_W-1:0]  ecc_in,
    output logic [DATA_W-1:0] data_out,
    output logic              err_sbe,
    output logic              err_dbe
);
    logic [ECC_W-1:0] syn;
    for (genvar r = 0; r < ECC_W; r++) begin : g_syn
        assign syn[r] = ^(data_in & HSIAO_ROWS[r]) ^ ecc_in[r];
    end
    // Odd syndrome flags SBE; a bit flips only when its column matches, so check-bit
    // errors and unmatched odd syndromes leave the data untouched.
    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        logic [ECC_W-1:0] col;
        for (genvar r = 0; r < ECC_W; r++) begin : g_col
            assign col[r] = HSIAO_ROWS[r][i];
        end
        assign data_out[i] = data_in[i] ^ (col == syn);
    end
    assign err_sbe = ^syn;
    assign err_dbe = (syn != '0) && !err_sbe;
endmodule

// File: rtl/ecc_encoder.sv
// ecc_encoder: Hsiao (72,64) check-bit generator
// Ports: data (64-bit in), ecc (8-bit check bits out).
module ecc_encoder import ecc_pkg::*; (
    input  logic [DATA_W-1:0] data,
    output logic [ECC_W-1:0]  ecc
);
    for (genvar r = 0; r < ECC_W; r++) begin : g_row
        assign ecc[r] = ^(data & HSIAO_ROWS[r]);
    end
endmodule

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: patrol scrubber that reads, checks and corrects every memory word
// Ports: clk, rst (sync, active high), scrub_en (run level), err_clr (clear pulse),
//   mem (bus master: request/response), mem_lock (hold off host writes for current word),
//   busy, pass_done (pulse after last address), sbe_cnt/dbe_cnt (saturating),
//   last_sbe_addr, first_dbe_addr (sticky since clear), dbe_irq (sticky).
module ecc_scrub_ctrl import ecc_pkg::*; #(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ECC_WIDTH  = ECC_W,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 65536,
    parameter int INTERVAL   = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scrub_en,
    input  logic                  err_clr,
    ecc_scrub_ctrl_if.master      mem,
    output logic                  mem_lock,
    output logic                  busy,
    output logic                  pass_done,
    output logic [CNT_WIDTH-1:0]  sbe_cnt,
    output logic [CNT_WIDTH-1:0]  dbe_cnt,
    output logic [ADDR_WIDTH-1:0] last_sbe_addr,
    output logic [ADDR_WIDTH-1:0] first_dbe_addr,
    output logic                  dbe_irq
);
    localparam int ICW = INTERVAL > 1 ? $clog2(INTERVAL) : 1;
    localparam logic [ICW-1:0] INT_LAST = ICW'(INTERVAL > 0 ? INTERVAL - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    scrub_state_t                       state;
    logic [ADDR_WIDTH-1:0]              ptr;
    logic [ICW-1:0]                     icnt;
    logic [DATA_WIDTH+ECC_WIDTH-1:0]    rdata_q;
    logic [DATA_WIDTH-1:0]              corr;
    logic [ECC_WIDTH-1:0]               enc;
    logic                               sbe;
    logic                               dbe;
    ecc_decoder u_dec (
        .data_in  (rdata_q[DATA_WIDTH-1:0]),
        .ecc_in   (rdata_q[DATA_WIDTH+:ECC_WIDTH]),
        .data_out (corr),
        .err_sbe  (sbe),
        .err_dbe  (dbe)
    );
    ecc_encoder u_enc (
        .data (corr),
        .ecc  (enc)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            ptr                <= '0;
            icnt               <= '0;
            rdata_q            <= '0;
            mem.mem_req_valid  <= 1'b0;
            mem.mem_req_we     <= 1'b0;
            mem.mem_req_addr   <= '0;
            mem.mem_req_wdata  <= '0;
            mem_lock           <= 1'b0;
            busy               <= 1'b0;
            pass_done          <= 1'b0;
            sbe_cnt            <= '0;
            dbe_cnt            <= '0;
            last_sbe_addr      <= '0;
            first_dbe_addr     <= '0;
            dbe_irq            <= 1'b0;
        end else begin
            pass_done <= 1'b0;
            case (state)
                IDLE: if (scrub_en) begin
                    state <= WAIT_INT;
                    icnt  <= '0;
                    busy  <= 1'b1;
                end
                WAIT_INT: if (icnt == INT_LAST) begin
                    state             <= RD_REQ;
                    mem.mem_req_valid <= 1'b1;
                    mem.mem_req_we    <= 1'b0;
                    mem.mem_req_addr  <= ptr;
                    mem_lock          <= 1'b1;
                end else begin
                    icnt <= icnt + 1'b1;
                end
                RD_REQ: if (mem.mem_req_ready) begin
                    state             <= RD_WAIT;
                    mem.mem_req_valid <= 1'b0;
                end
                RD_WAIT: if (mem.mem_rsp_valid) begin
                    rdata_q <= mem.mem_rsp_rdata;
                    state   <= CHECK;
                end
                CHECK: if (sbe) begin
                    sbe_cnt           <= (&sbe_cnt) ? sbe_cnt : sbe_cnt + 1'b1;
                    last_sbe_addr     <= ptr;
                    mem.mem_req_wdata <= {enc, corr};
                    mem.mem_req_valid <= 1'b1;
                    mem.mem_req_we    <= 1'b1;
                    state             <= WB_REQ;
                end else begin
                    if (dbe) begin
                        dbe_cnt <= (&dbe_cnt) ? dbe_cnt : dbe_cnt + 1'b1;
                        if (dbe_cnt == '0) first_dbe_addr <= ptr;
                        dbe_irq <= 1'b1;
                    end
                    mem_lock <= 1'b0;
                    state    <= ADVANCE;
                end
                WB_REQ: if (mem.mem_req_ready) begin
                    mem.mem_req_valid <= 1'b0;
                    mem.mem_req_we    <= 1'b0;
                    mem_lock          <= 1'b0;
                    state             <= ADVANCE;
                end
                ADVANCE: begin
                    ptr       <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
                    pass_done <= ptr == LAST_ADDR;
                    icnt      <= '0;
                    busy      <= scrub_en;
                    state     <= scrub_en ? WAIT_INT : IDLE;
                end
                default: state <= IDLE;
            endcase
            // Clear has priority over any log update made in the same cycle.
            if (err_clr) begin
                sbe_cnt        <= '0;
                dbe_cnt        <= '0;
                last_sbe_addr  <= '0;
                first_dbe_addr <= '0;
                dbe_irq        <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb_ecc_scrub_ctrl: directed + randomized bench for ecc_scrub_ctrl against a word-level model
module tb_ecc_scrub_ctrl;
    import ecc_pkg::*;
    localparam int AW = 16;
    localparam int DEPTH = 8;
    localparam int INTERVAL = 4;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;
    logic clk = 1'b0;
    logic rst, scrub_en, err_clr;
    logic mem_lock, busy, pass_done, dbe_irq;
    logic [CW-1:0] sbe_cnt, dbe_cnt;
    logic [AW-1:0] last_sbe_addr, first_dbe_addr;
    ecc_scrub_ctrl_if #(.ADDR_WIDTH(AW)) m();
    ecc_scrub_ctrl #(
        .ADDR_WIDTH(AW), .DEPTH(DEPTH), .INTERVAL(INTERVAL), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .scrub_en(scrub_en), .err_clr(err_clr), .mem(m),
        .mem_lock(mem_lock), .busy(busy), .pass_done(pass_done),
        .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt), .last_sbe_addr(last_sbe_addr),
        .first_dbe_addr(first_dbe_addr), .dbe_irq(dbe_irq)
    );
    always #5 clk = ~clk;
    logic [71:0] mem [DEPTH];
    logic [63:0] gold [DEPTH];
    logic [71:0] err [DEPTH];
    int checks = 0, failures = 0, pd_cnt = 0;
    int rd_q[$];
    int wr_a[$];
    logic [71:0] wr_d[$];
    bit pend = 0, rsp_hold = 0, ready_low = 0;
    int lat = 0, pend_addr = 0;
    int m_sbe = 0, m_dbe = 0, m_last = 0, m_first = 0, m_irq = 0;
    function automatic logic [71:0] clean(input logic [63:0] d);
        logic [7:0] e;
        for (int r = 0; r < 8; r++) e[r] = ^(d & HSIAO_ROWS[r]);
        return {e, d};
    endfunction
    // 0 = clean, 1 = single-bit or unmatched odd syndrome (written back), 2 = double-bit
    function automatic int cls(input logic [71:0] e);
        if (e == '0) return 0;
        if ($countones(e) == 1 || e == {8'h7F, 64'h0}) return 1;
        return 2;
    endfunction
    function automatic logic [71:0] bit72(input int k);
        logic [71:0] one = 72'd1;
        return one << k;
    endfunction
    // memory slave: accept requests, reply to reads after a random latency
    always @(posedge clk) begin
        if (m.mem_req_valid && m.mem_req_ready) begin
            if (m.mem_req_we) begin
                wr_a.push_back(int'(m.mem_req_addr));
                wr_d.push_back(m.mem_req_wdata);
                mem[m.mem_req_addr[2:0]] = m.mem_req_wdata;
            end else begin
                rd_q.push_back(int'(m.mem_req_addr));
                pend = 1;
                pend_addr = int'(m.mem_req_addr);
                lat = $urandom_range(0, 3);
            end
        end
    end
    always @(negedge clk) begin
        m.mem_rsp_valid = 1'b0;
        if (pend && !rsp_hold) begin
            if (lat == 0) begin
                m.mem_rsp_valid = 1'b1;
                m.mem_rsp_rdata = mem[pend_addr[2:0]];
                pend = 0;
            end else lat--;
        end
        m.mem_req_ready = !ready_low && ($urandom_range(0, 3) != 0);
        if (pass_done) pd_cnt++;
    end
    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic prep();
        for (int i = 0; i < DEPTH; i++) begin
            gold[i] = {$urandom, $urandom};
            mem[i] = clean(gold[i]) ^ err[i];
        end
    endtask
    task automatic clear_err();
        for (int i = 0; i < DEPTH; i++) err[i] = '0;
    endtask
    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        m_sbe = 0; m_dbe = 0; m_last = 0; m_first = 0; m_irq = 0;
        chk("clr_sbe_cnt", sbe_cnt, 0);
        chk("clr_dbe_cnt", dbe_cnt, 0);
        chk("clr_first_dbe", first_dbe_addr, 0);
        chk("clr_irq", dbe_irq, 0);
    endtask
    task automatic wait_idle(input string tag);
        for (int k = 0; k < 1000 && busy; k++) @(negedge clk);
        chk(tag, busy, 0);
    endtask
    task automatic wait_reads(input string tag, input int n);
        for (int k = 0; k < 4000 && rd_q.size() < n; k++) @(negedge clk);
        chk(tag, rd_q.size(), n);
    endtask
    // full pass from address 0, checked against the word-level model
    task automatic run_pass(input string tag);
        int ew[$];
        logic [71:0] expm [DEPTH];
        int pd0;
        prep();
        for (int i = 0; i < DEPTH; i++) begin
            expm[i] = mem[i];
            if (cls(err[i]) == 1) begin
                ew.push_back(i);
                m_sbe = (m_sbe < CMAX) ? m_sbe + 1 : CMAX;
                m_last = i;
                expm[i] = clean(gold[i]);
            end else if (cls(err[i]) == 2) begin
                if (m_dbe == 0) m_first = i;
                m_dbe = (m_dbe < CMAX) ? m_dbe + 1 : CMAX;
                m_irq = 1;
            end
        end
        rd_q.delete(); wr_a.delete(); wr_d.delete();
        pd0 = pd_cnt;
        scrub_en = 1'b1;
        wait_reads({tag, "_reads"}, DEPTH);
        scrub_en = 1'b0;
        wait_idle({tag, "_idle"});
        @(negedge clk);
        chk({tag, "_pass_done"}, pd_cnt - pd0, 1);
        for (int i = 0; i < rd_q.size() && i < DEPTH; i++) chk($sformatf("%s_rd_addr%0d", tag, i), rd_q[i], i);
        chk({tag, "_wr_count"}, wr_a.size(), ew.size());
        for (int i = 0; i < wr_a.size() && i < ew.size(); i++) begin
            chk($sformatf("%s_wr_addr%0d", tag, i), wr_a[i], ew[i]);
            chk($sformatf("%s_wr_data%0d", tag, i), wr_d[i], clean(gold[ew[i]]));
        end
        for (int i = 0; i < DEPTH; i++) chk($sformatf("%s_mem%0d", tag, i), mem[i], expm[i]);
        chk({tag, "_sbe_cnt"}, sbe_cnt, m_sbe);
        chk({tag, "_dbe_cnt"}, dbe_cnt, m_dbe);
        chk({tag, "_last_sbe"}, last_sbe_addr, m_last);
        chk({tag, "_first_dbe"}, first_dbe_addr, m_first);
        chk({tag, "_irq"}, dbe_irq, m_irq);
        chk({tag, "_lock"}, mem_lock, 0);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int a, b, n0;
        rst = 1'b1; scrub_en = 1'b0; err_clr = 1'b0;
        m.mem_req_ready = 1'b0; m.mem_rsp_valid = 1'b0; m.mem_rsp_rdata = '0;
        clear_err();
        prep();
        repeat (3) @(negedge clk);
        chk("rst_valid", m.mem_req_valid, 0);
        chk("rst_we", m.mem_req_we, 0);
        chk("rst_addr", m.mem_req_addr, 0);
        chk("rst_wdata", m.mem_req_wdata, 0);
        chk("rst_lock", mem_lock, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pass_done", pass_done, 0);
        chk("rst_cnts", {sbe_cnt, dbe_cnt, dbe_irq}, 0);
        chk("rst_addrs", {last_sbe_addr, first_dbe_addr}, 0);
        rst = 1'b0;
        @(negedge clk);
        // clean memory
        run_pass("clean");
        // single data-bit error at address 3
        err[3] = bit72(0);
        run_pass("sbe3");
        // double-bit errors at 5 and 6; first_dbe_addr must stay at 5
        clear_err();
        err[5] = bit72(0) | bit72(1);
        err[6] = bit72(10) | bit72(40);
        run_pass("dbe56");
        pulse_clr();
        chk("clr_last_sbe", last_sbe_addr, 0);
        // unmatched odd syndrome, random single-bit and random double-bit errors
        clear_err();
        err[2] = {8'h7F, 64'h0};
        err[6] = bit72($urandom_range(0, 71));
        a = $urandom_range(0, 71);
        b = (a + 1 + $urandom_range(0, 70)) % 72;
        err[4] = bit72(a) | bit72(b);
        run_pass("mixed");
        // five SBEs saturate a 2-bit counter at 3
        pulse_clr();
        clear_err();
        foreach (err[i]) if (i != 3 && i != 5 && i != 6) err[i] = bit72($urandom_range(0, 71));
        run_pass("sat");
        // write-back stalled by ready low; scrub_en dropped mid-word
        pulse_clr();
        clear_err();
        err[1] = bit72($urandom_range(0, 71));
        prep();
        rd_q.delete(); wr_a.delete(); wr_d.delete();
        scrub_en = 1'b1;
        wait_reads("wb_reads", 2);
        chk("wb_rd_addr", rd_q.size() > 1 ? rd_q[1] : -1, 1);
        ready_low = 1;
        scrub_en = 1'b0;
        for (int k = 0; k < 200 && !(m.mem_req_valid && m.mem_req_we); k++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("wb_hold%0d", k),
                {m.mem_req_valid, m.mem_req_we, mem_lock, m.mem_req_addr == 1, m.mem_req_wdata == clean(gold[1])}, 5'b11111);
            @(negedge clk);
        end
        chk("wb_no_write_while_stalled", wr_a.size(), 0);
        ready_low = 0;
        wait_idle("wb_idle");
        chk("wb_count", wr_a.size(), 1);
        chk("wb_addr", wr_a.size() > 0 ? wr_a[0] : -1, 1);
        chk("wb_data", wr_d.size() > 0 ? wr_d[0] : '0, clean(gold[1]));
        chk("wb_lock_released", mem_lock, 0);
        chk("wb_sbe_cnt", sbe_cnt, 1);
        chk("wb_last_sbe", last_sbe_addr, 1);
        // scrub_en dropped while waiting for read data at address 2
        rsp_hold = 1;
        n0 = rd_q.size();
        scrub_en = 1'b1;
        wait_reads("stop_reads", n0 + 1);
        chk("stop_rd_addr", rd_q[$], 2);
        scrub_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("stop_still_busy", {busy, mem_lock}, 2'b11);
        rsp_hold = 0;
        wait_idle("stop_idle");
        chk("stop_no_extra_read", rd_q.size(), n0 + 1);
        scrub_en = 1'b1;
        wait_reads("resume_reads", n0 + 2);
        chk("resume_addr", rd_q[$], 3);
        scrub_en = 1'b0;
        wait_idle("resume_idle");
        // reset while waiting for read data; the late response must be ignored
        rsp_hold = 1;
        n0 = rd_q.size();
        scrub_en = 1'b1;
        wait_reads("rst_reads", n0 + 1);
        scrub_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rsp_hold = 0;
        repeat (6) @(negedge clk);
        chk("late_valid", {m.mem_req_valid, m.mem_req_we, busy, mem_lock, pass_done}, 0);
        chk("late_cnts", {sbe_cnt, dbe_cnt, dbe_irq}, 0);
        chk("late_addrs", {m.mem_req_addr, last_sbe_addr, first_dbe_addr}, 0);
        chk("late_no_read", rd_q.size(), n0 + 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
